// File: rtl/green_interp_stream.sv
// rtl/green_interp_stream.sv - three-stage Bayer green-channel interpolator on a ready/valid pixel stream
module green_interp_stream #(
    parameter int PW = 12,
    parameter int TW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic          in_eol,
    input  logic [PW-1:0] p_n2,
    input  logic [PW-1:0] p_n1,
    input  logic [PW-1:0] p_c,
    input  logic [PW-1:0] p_s1,
    input  logic [PW-1:0] p_s2,
    input  logic [PW-1:0] p_w2,
    input  logic [PW-1:0] p_w1,
    input  logic [PW-1:0] p_e1,
    input  logic [PW-1:0] p_e2,
    input  logic [1:0]    cfa_pattern,
    input  logic [1:0]    mode,
    input  logic [TW-1:0] blend_th,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_pix,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_green_site
);

    localparam int SW = PW + 4;
    localparam int DW = PW + 2;
    localparam int CW = PW + 3;

    typedef struct packed {
        logic          valid;
        logic          sof;
        logic          eol;
        logic          green;
        logic [1:0]    mode;
        logic [TW-1:0] th;
        logic [PW-1:0] n2;
        logic [PW-1:0] n1;
        logic [PW-1:0] c;
        logic [PW-1:0] s1;
        logic [PW-1:0] s2;
        logic [PW-1:0] w2;
        logic [PW-1:0] w1;
        logic [PW-1:0] e1;
        logic [PW-1:0] e2;
    } s1_t;

    typedef struct packed {
        logic          valid;
        logic          sof;
        logic          eol;
        logic          green;
        logic [1:0]    mode;
        logic [TW-1:0] th;
        logic [PW-1:0] c;
        logic [PW-1:0] gh;
        logic [PW-1:0] gv;
        logic [PW-1:0] bil;
        logic [DW-1:0] dh;
        logic [DW-1:0] dv;
    } s2_t;

    typedef struct packed {
        logic          valid;
        logic          sof;
        logic          eol;
        logic          green;
        logic [PW-1:0] pix;
    } s3_t;

    // Directional estimate: (2*(a1+b1) + 2*c - a2 - b2) / 4, floored, clamped to the pixel range.
    function automatic logic [PW-1:0] estimate(input logic [PW-1:0] a2, input logic [PW-1:0] a1,
                                               input logic [PW-1:0] c, input logic [PW-1:0] b1,
                                               input logic [PW-1:0] b2);
        logic signed [SW-1:0] sum;
        logic signed [SW-1:0] q;
        logic [PW-1:0]        r;
        sum = $signed(((SW'(a1) + SW'(b1) + SW'(c)) << 1) - SW'(a2) - SW'(b2));
        q   = sum >>> 2;
        if (q[SW-1]) begin
            r = '0;
        end else if (|q[SW-2:PW]) begin
            r = '1;
        end else begin
            r = q[PW-1:0];
        end
        return r;
    endfunction

    // Gradient magnitude: |a1-b1| + |2*c-a2-b2|; the widths leave no room for overflow.
    function automatic logic [DW-1:0] gradient(input logic [PW-1:0] a2, input logic [PW-1:0] a1,
                                               input logic [PW-1:0] c, input logic [PW-1:0] b1,
                                               input logic [PW-1:0] b2);
        logic [PW-1:0] d1;
        logic [PW:0]   t;
        logic [PW:0]   u;
        logic [PW:0]   d2;
        d1 = (a1 >= b1) ? (a1 - b1) : (b1 - a1);
        t  = {c, 1'b0};
        u  = {1'b0, a2} + {1'b0, b2};
        d2 = (t >= u) ? (t - u) : (u - t);
        return DW'(d1) + DW'(d2);
    endfunction

    s1_t           s1_q, s1_d;
    s2_t           s2_q, s2_d;
    s3_t           s3_q, s3_d;
    logic          x_par_q, x_par_d;
    logic          y_par_q, y_par_d;
    logic [1:0]    cfa_q, cfa_d;
    logic [1:0]    mode_q, mode_d;
    logic [TW-1:0] th_q, th_d;

    logic          enable;
    logic          accept;
    logic          bx, by;
    logic [1:0]    cfa_eff;
    logic [1:0]    mode_eff;
    logic [TW-1:0] th_eff;
    logic          green_eff;

    // Global stall: every stage moves only when the output slot is free or being drained.
    always_comb begin
        enable   = !s3_q.valid || out_ready;
        in_ready = enable && !rst;
        accept   = in_valid && in_ready;
    end

    // Beat phase and frame configuration; an sof beat starts at (0,0) and uses its own config.
    always_comb begin
        bx        = in_sof ? 1'b0 : x_par_q;
        by        = in_sof ? 1'b0 : y_par_q;
        cfa_eff   = in_sof ? cfa_pattern : cfa_q;
        mode_eff  = in_sof ? mode : mode_q;
        th_eff    = in_sof ? blend_th : th_q;
        green_eff = ((cfa_eff == 2'd0) || (cfa_eff == 2'd3)) ? (bx ^ by) : ~(bx ^ by);
        x_par_d   = x_par_q;
        y_par_d   = y_par_q;
        cfa_d     = cfa_q;
        mode_d    = mode_q;
        th_d      = th_q;
        if (accept) begin
            if (in_eol) begin
                x_par_d = 1'b0;
                y_par_d = ~by;
            end else begin
                x_par_d = ~bx;
                y_par_d = by;
            end
            if (in_sof) begin
                cfa_d  = cfa_pattern;
                mode_d = mode;
                th_d   = blend_th;
            end
        end
    end

    // Stage 1: capture the window with its resolved phase and configuration.
    always_comb begin
        s1_d = s1_q;
        if (enable) begin
            s1_d.valid = accept;
            s1_d.sof   = in_sof;
            s1_d.eol   = in_eol;
            s1_d.green = green_eff;
            s1_d.mode  = mode_eff;
            s1_d.th    = th_eff;
            s1_d.n2    = p_n2;
            s1_d.n1    = p_n1;
            s1_d.c     = p_c;
            s1_d.s1    = p_s1;
            s1_d.s2    = p_s2;
            s1_d.w2    = p_w2;
            s1_d.w1    = p_w1;
            s1_d.e1    = p_e1;
            s1_d.e2    = p_e2;
        end
    end

    // Stage 2: both directional estimates, both gradients and the bilinear average.
    always_comb begin
        logic [DW-1:0] bsum;
        s2_d = s2_q;
        bsum = DW'(s1_q.n1) + DW'(s1_q.s1) + DW'(s1_q.w1) + DW'(s1_q.e1) + DW'(2);
        if (enable) begin
            s2_d.valid = s1_q.valid;
            s2_d.sof   = s1_q.sof;
            s2_d.eol   = s1_q.eol;
            s2_d.green = s1_q.green;
            s2_d.mode  = s1_q.mode;
            s2_d.th    = s1_q.th;
            s2_d.c     = s1_q.c;
            s2_d.gh    = estimate(s1_q.w2, s1_q.w1, s1_q.c, s1_q.e1, s1_q.e2);
            s2_d.gv    = estimate(s1_q.n2, s1_q.n1, s1_q.c, s1_q.s1, s1_q.s2);
            s2_d.dh    = gradient(s1_q.w2, s1_q.w1, s1_q.c, s1_q.e1, s1_q.e2);
            s2_d.dv    = gradient(s1_q.n2, s1_q.n1, s1_q.c, s1_q.s1, s1_q.s2);
            s2_d.bil   = bsum[DW-1:2];
        end
    end

    // Stage 3: pick the green value by site and mode; this register is the output beat.
    always_comb begin
        logic [CW-1:0] h_cost;
        logic [CW-1:0] v_cost;
        logic [PW:0]   asum;
        logic [PW-1:0] dir;
        s3_d   = s3_q;
        h_cost = CW'(s2_q.dh) + CW'(s2_q.th);
        v_cost = CW'(s2_q.dv) + CW'(s2_q.th);
        asum   = {1'b0, s2_q.gh} + {1'b0, s2_q.gv} + (PW + 1)'(1);
        if (h_cost < CW'(s2_q.dv)) begin
            dir = s2_q.gh;
        end else if (v_cost < CW'(s2_q.dh)) begin
            dir = s2_q.gv;
        end else begin
            dir = asum[PW:1];
        end
        if (enable) begin
            s3_d.valid = s2_q.valid;
            s3_d.sof   = s2_q.sof;
            s3_d.eol   = s2_q.eol;
            s3_d.green = s2_q.green;
            if (s2_q.green) begin
                s3_d.pix = s2_q.c;
            end else begin
                case (s2_q.mode)
                    2'd0:    s3_d.pix = dir;
                    2'd1:    s3_d.pix = s2_q.bil;
                    default: s3_d.pix = s2_q.c;
                endcase
            end
        end
    end

    // State registers; reset drops every in-flight beat and the frame configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            x_par_q <= 1'b0;
            y_par_q <= 1'b0;
            cfa_q   <= '0;
            mode_q  <= '0;
            th_q    <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            x_par_q <= x_par_d;
            y_par_q <= y_par_d;
            cfa_q   <= cfa_d;
            mode_q  <= mode_d;
            th_q    <= th_d;
        end
    end

    // Output beat straight from the stage-3 register.
    always_comb begin
        out_valid      = s3_q.valid;
        out_pix        = s3_q.pix;
        out_sof        = s3_q.sof;
        out_eol        = s3_q.eol;
        out_green_site = s3_q.green;
    end

endmodule

// File: tb/tb_green_interp_stream.sv
// tb/tb_green_interp_stream.sv - scoreboard bench for green_interp_stream
module tb_green_interp_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic        in_eol = 1'b0;
    logic [11:0] p_n2 = '0, p_n1 = '0, p_c = '0, p_s1 = '0, p_s2 = '0;
    logic [11:0] p_w2 = '0, p_w1 = '0, p_e1 = '0, p_e2 = '0;
    logic [1:0]  cfa_pattern = '0;
    logic [1:0]  mode = '0;
    logic [12:0] blend_th = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_pix;
    logic        out_sof, out_eol, out_green_site;

    typedef struct packed {
        logic [11:0] pix;
        logic        sof;
        logic        eol;
        logic        green;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          accepted = 0;
    int          last_acc = 0;
    int          last_hs = 0;
    logic        stalled_prev = 1'b0;
    logic [14:0] snap = '0;

    green_interp_stream #(.PW(12), .TW(13)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_eol(in_eol),
        .p_n2(p_n2), .p_n1(p_n1), .p_c(p_c), .p_s1(p_s1), .p_s2(p_s2),
        .p_w2(p_w2), .p_w1(p_w1), .p_e1(p_e1), .p_e2(p_e2),
        .cfa_pattern(cfa_pattern), .mode(mode), .blend_th(blend_th),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_sof(out_sof), .out_eol(out_eol), .out_green_site(out_green_site)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp_v);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks hold-stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat act pix=%0d sof=%0b eol=%0b green=%0b exp none",
                         out_pix, out_sof, out_eol, out_green_site);
            end else begin
                e = sb.pop_front();
                if ({out_pix, out_sof, out_eol, out_green_site} !== {e.pix, e.sof, e.eol, e.green}) begin
                    bad++;
                    $display("FAIL out_beat act pix=%0d sof=%0b eol=%0b green=%0b exp pix=%0d sof=%0b eol=%0b green=%0b",
                             out_pix, out_sof, out_eol, out_green_site, e.pix, e.sof, e.eol, e.green);
                end
            end
            last_hs = cyc + 1;
        end
        if (!rst && out_valid && !out_ready) begin
            if (stalled_prev) begin
                total++;
                if ({out_pix, out_sof, out_eol, out_green_site} !== snap) begin
                    bad++;
                    $display("FAIL stall_hold act=%0h exp=%0h",
                             {out_pix, out_sof, out_eol, out_green_site}, snap);
                end
            end
            snap         = {out_pix, out_sof, out_eol, out_green_site};
            stalled_prev = 1'b1;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    // Drive one beat, optionally queue its expected output, and wait (bounded) for acceptance.
    task automatic beat(input int n2, input int n1, input int c, input int s1, input int s2,
                        input int w2, input int w1, input int e1, input int e2,
                        input logic sof, input logic eol, input logic [1:0] cfa, input logic [1:0] md,
                        input int th, input int ep, input logic eg, input logic push);
        logic ok;
        p_n2 = 12'(n2); p_n1 = 12'(n1); p_c = 12'(c); p_s1 = 12'(s1); p_s2 = 12'(s2);
        p_w2 = 12'(w2); p_w1 = 12'(w1); p_e1 = 12'(e1); p_e2 = 12'(e2);
        in_sof = sof; in_eol = eol; cfa_pattern = cfa; mode = md; blend_th = 13'(th);
        if (push) sb.push_back('{pix: 12'(ep), sof: sof, eol: eol, green: eg});
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout act=not_accepted exp=accepted");
        end else begin
            accepted++;
            last_acc = cyc;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout act=%0d exp=0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_pix", int'(out_pix), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // flat field, red site, latency
        beat(100, 100, 100, 100, 100, 100, 100, 100, 100, 1, 0, 0, 0, 0, 100, 0, 1);
        drain();
        chk("latency", last_hs - last_acc, 3);

        // horizontal wins, vertical wins, clamp/tie
        beat(200, 1000, 200, 0, 200, 200, 200, 200, 200, 1, 0, 0, 0, 10, 200, 0, 1);
        beat(200, 200, 200, 200, 200, 200, 1000, 0, 200, 1, 0, 0, 0, 10, 200, 0, 1);
        beat(0, 0, 4095, 0, 0, 0, 4095, 4095, 0, 1, 0, 0, 0, 0, 3071, 0, 1);
        // pattern 0: red then green
        beat(100, 100, 300, 100, 100, 100, 100, 100, 100, 1, 0, 0, 0, 0, 200, 0, 1);
        beat(100, 100, 777, 100, 100, 100, 100, 100, 100, 0, 0, 0, 0, 0, 777, 1, 1);
        // pattern 1: green then red
        beat(100, 100, 300, 100, 100, 100, 100, 100, 100, 1, 0, 1, 0, 0, 300, 1, 1);
        beat(100, 100, 777, 100, 100, 100, 100, 100, 100, 0, 0, 1, 0, 0, 438, 0, 1);
        // sof+eol on one beat: next beat is (0,1), then (1,1)
        beat(100, 100, 300, 100, 100, 100, 100, 100, 100, 1, 1, 0, 0, 0, 200, 0, 1);
        beat(100, 100, 777, 100, 100, 100, 100, 100, 100, 0, 0, 0, 0, 0, 777, 1, 1);
        beat(100, 100, 300, 100, 100, 100, 100, 100, 100, 0, 0, 0, 0, 0, 200, 0, 1);
        // bilinear
        beat(0, 10, 500, 20, 0, 0, 30, 41, 0, 1, 0, 0, 1, 0, 25, 0, 1);
        // bypass frame; later non-sof config inputs must be ignored
        beat(100, 100, 555, 100, 100, 100, 100, 100, 100, 1, 1, 0, 2, 0, 555, 0, 1);
        beat(100, 100, 777, 100, 100, 100, 100, 100, 100, 0, 0, 0, 2, 0, 777, 1, 1);
        beat(100, 100, 300, 100, 100, 100, 100, 100, 100, 0, 0, 1, 0, 0, 300, 0, 1);
        drain();

        // backpressure: 6 beats against a stalled output
        out_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    beat(0, 10 * (i + 1), 1000 + i, 10 * (i + 1), 0, 0, 10 * (i + 1), 10 * (i + 1), 0,
                         (i == 0), 0, 0, 1, 0, (i % 2 == 1) ? 1000 + i : 10 * (i + 1), (i % 2 == 1), 1);
                end
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                chk("bp_accepted", accepted, 3);
                chk("bp_in_ready", int'(in_ready), 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // reset with two beats in flight
        beat(100, 100, 300, 100, 100, 100, 100, 100, 100, 1, 0, 1, 1, 5, 0, 0, 0);
        beat(100, 100, 300, 100, 100, 100, 100, 100, 100, 0, 0, 1, 1, 5, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_in_rst", int'(in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        beat(100, 100, 300, 100, 100, 100, 100, 100, 100, 0, 0, 1, 1, 0, 200, 0, 1);
        beat(100, 100, 300, 100, 100, 100, 100, 100, 100, 1, 0, 0, 1, 0, 100, 0, 1);
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
